dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial transmitter for the 16-bit SPI DAC on the GPIO_1 header (DIN, SCLK, SYNC). It accepts one sample per valid/ready handshake from the sample source inside the SoC fabric and shifts a 24-bit frame to the DAC. Its outputs drive the `dac_din`, `dac_clk` and `dac_sync` pins directly.

## Interface
- `DATA_WIDTH`, 16: sample width.
- `FRAME_BITS`, 24: bits per SYNC-low frame; must be ≥ DATA_WIDTH+2.
- `CLK_DIV`, 2: `clk` cycles per SCLK half-period; must be ≥ 1.
- `SYNC_IDLE`, 2: minimum `clk` cycles SYNC stays high between frames and after reset; must be ≥ 1.
- `clk`  in  1  fabric clock (50 MHz). One clock domain only.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_valid`  in  1  sample available.
- `s_ready`  out  1  block can accept a sample.
- `s_data`  in  DATA_WIDTH  sample code, unsigned.
- `s_mode`  in  2  DAC power mode, captured with the sample.
- `dac_sync`  out  1  frame select, active-low.
- `dac_clk`  out  1  SCLK; idles high.
- `dac_din`  out  1  serial data, MSB first.
- `busy`  out  1  high from handshake until `s_ready` returns.
- `frame_done`  out  1  one-cycle pulse on the cycle SYNC rises after a complete frame.

## Operation
- Frame word: {(FRAME_BITS-DATA_WIDTH-2) zeros, s_mode, s_data}. It is captured into a shift register on the handshake. Later changes to `s_data` or `s_mode` have no effect on the frame in flight.
- FSM states: IDLE, SETUP, SHIFT, GAP.
- IDLE: `s_ready`=1 and SYNC high. If `s_valid` is high at a clock edge, the block captures the frame and moves to SETUP.
- SETUP: SYNC low, SCLK high, DIN = frame MSB. Lasts CLK_DIV cycles, then moves to SHIFT.
- SHIFT: each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - The DAC samples on the SCLK falling edge.
  - DIN advances to the next bit on the SCLK rising edge. DIN is stable for the whole low phase.
  - The high phase of the last bit is the SYNC hold time.
- After the last bit, SYNC goes high, `frame_done` pulses, and the FSM moves to GAP.
- GAP: SYNC high, `s_ready`=0 for SYNC_IDLE cycles, then IDLE.
- Bit counter counts 0..FRAME_BITS-1. The phase counter reloads every half-period. No wrap occurs beyond the frame.
- Reset (async, any state):
  - `dac_sync`=1, `dac_clk`=1, `dac_din`=0, `s_ready`=0, `busy`=0, `frame_done`=0.
  - The FSM enters GAP with a full SYNC_IDLE count, so an aborted frame is always followed by SYNC high for at least SYNC_IDLE cycles. The DAC discards a partial frame.
- `s_valid` while `s_ready`=0 is ignored. The source must hold `s_valid` and its data until the handshake.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge T:
  - SYNC falls at T+1.
  - First SCLK falling edge at T+1+CLK_DIV.
  - SYNC low for CLK_DIV·(1+2·FRAME_BITS) cycles.
  - SYNC rises and `frame_done` pulses at T+1+CLK_DIV·(1+2·FRAME_BITS).
  - `s_ready` rises SYNC_IDLE cycles later.
- Defaults:
  - SYNC low T+1..T+98; `frame_done` at T+99; `s_ready` at T+101.
  - Sample period 101 cycles; 12.5 MHz SCLK.
- After `rst_n` deasserts, `s_ready` rises after SYNC_IDLE clock edges.
- `busy` is high from T+1 until the cycle `s_ready` rises.

## Structure
- Package `dac_pkg` holds:
  - the state enum;
  - mode constants: MODE_NORMAL=2'b00, MODE_PD_1K=2'b01, MODE_PD_100K=2'b10, MODE_PD_TRI=2'b11;
  - the function computing frame length in cycles.
- Sub-module `dac_sclk_div` is a half-period tick generator (phase counter, reload, tick output) enabled only outside IDLE. The shift register and FSM stay in `dac_spi_tx`.

## Test plan
- Reset release, no traffic:
  - SYNC=1, SCLK=1, DIN=0 throughout.
  - `s_ready` rises exactly 2 cycles after release.
- Single sample 16'hA5C3, mode 00:
  - 24 falling edges sampled by a bench DAC model read 24'h00A5C3.
  - SYNC low for 98 cycles; `frame_done` at T+99.
- Back-to-back samples 16'h0000 then 16'hFFFF with `s_valid` held high:
  - Second handshake occurs at T+101.
  - Frames decode as 24'h000000 and 24'h00FFFF.
- Mode 2'b11, data 16'h1234: frame decodes as 24'h031234.
- `rst_n` pulsed low at bit 10 of a frame:
  - SYNC goes high immediately.
  - SCLK stays high.
  - The bench model discards the partial frame.
  - The next sample is sent intact.
- `s_data` toggled while `s_ready`=0 mid-frame: frame in flight is unchanged and no extra handshake occurs.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the SPI DAC transmitter.
package dac_pkg;

    localparam int unsigned MODE_W = 2;

    // Transmitter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_e;

    // DAC power-mode codes carried in the two bits above the sample
    localparam logic [MODE_W-1:0] MODE_NORMAL  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_PD_1K   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_PD_100K = 2'b10;
    localparam logic [MODE_W-1:0] MODE_PD_TRI  = 2'b11;

    // Cycles SYNC is held low for one frame: setup half-period plus two half-periods per bit
    function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                                 input int unsigned frame_bits);
        return clk_div * (1 + 2 * frame_bits);
    endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period tick generator for SCLK; the phase restarts whenever it is disabled.
module dac_sclk_div
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_c_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count down through a half-period, reload on the tick or while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Tick marks the last clk cycle of the current half-period
    assign tick_c_o = en_i && (cnt_q == '0);

    // Phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serial frame transmitter for a 16-bit SPI DAC (DIN/SCLK/SYNC), one sample per handshake.
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_BITS = 24,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned SYNC_IDLE  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [MODE_W-1:0]     s_mode,
    output logic                  dac_sync,
    output logic                  dac_clk,
    output logic                  dac_din,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int unsigned GAP_W = (SYNC_IDLE > 1) ? $clog2(SYNC_IDLE) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SYNC_IDLE - 1);

    dac_state_e             state_q,   state_d;
    logic [FRAME_BITS-1:0]  shreg_q,   shreg_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   sync_q,    sync_d;
    logic                   sclk_q,    sclk_d;
    logic                   din_q,     din_d;
    logic                   ready_q,   ready_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;

    logic                   div_en;
    logic                   tick;
    logic [FRAME_BITS-1:0]  frame_w;

    // Frame word: zero padding, power mode, then the sample
    assign frame_w = FRAME_BITS'({s_mode, s_data});

    // SCLK timing only runs while a frame is on the wire
    assign div_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

    dac_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (div_en),
        .tick_c_o (tick)
    );

    // Next-state and output logic; DIN moves only when SCLK rises
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sync_d    = sync_q;
        sclk_d    = sclk_q;
        din_d     = din_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sync_d  = 1'b1;
                sclk_d  = 1'b1;
                ready_d = 1'b1;
                if (s_valid) begin
                    state_d   = ST_SETUP;
                    din_d     = frame_w[FRAME_BITS-1];
                    shreg_d   = {frame_w[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = '0;
                    sync_d    = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        din_d   = shreg_q[FRAME_BITS-1];
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    end else if (bit_cnt_q == LAST_BIT) begin
                        // Last high phase doubles as SYNC hold; close the frame
                        state_d   = ST_GAP;
                        sync_d    = 1'b1;
                        din_d     = 1'b0;
                        done_d    = 1'b1;
                        gap_cnt_d = GAP_RELOAD;
                    end else begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    // State and output registers; reset parks in GAP so SYNC idles before the first frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_GAP;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= GAP_RELOAD;
            sync_q    <= 1'b1;
            sclk_q    <= 1'b1;
            din_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sync_q    <= sync_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready    = ready_q;
    assign dac_sync   = sync_q;
    assign dac_clk    = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx with a behavioural DAC receiver model.
module tb_dac_spi_tx;
    import dac_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned FB = 24;
    localparam int unsigned CD = 2;
    localparam int unsigned SI = 2;
    localparam int L      = int'(CD) * (1 + 2 * int'(FB));   // SYNC-low cycles
    localparam int PERIOD = L + int'(SI) + 1;                 // handshake-to-handshake

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic [1:0]    s_mode  = '0;
    logic          s_ready;
    logic          dac_sync, dac_clk, dac_din, busy, frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    dac_spi_tx #(
        .DATA_WIDTH (DW),
        .FRAME_BITS (FB),
        .CLK_DIV    (CD),
        .SYNC_IDLE  (SI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_mode     (s_mode),
        .dac_sync   (dac_sync),
        .dac_clk    (dac_clk),
        .dac_din    (dac_din),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DAC receiver model: shift DIN on SCLK falls while SYNC low, keep only complete frames
    logic [FB-1:0] frames[$];
    logic [FB-1:0] dac_sr      = '0;
    int            dac_bits    = 0;
    int            stray_falls = 0;
    always begin
        @(negedge dac_clk or posedge dac_sync);
        #1;
        if (dac_sync === 1'b1) begin
            if (dac_clk === 1'b0) begin
                stray_falls = stray_falls + 1;
            end else begin
                if (dac_bits == int'(FB)) frames.push_back(dac_sr);
                dac_bits = 0;
                dac_sr   = '0;
            end
        end else begin
            dac_sr   = {dac_sr[FB-2:0], dac_din};
            dac_bits = dac_bits + 1;
        end
    end

    // DIN must not move while SCLK stays low inside a frame
    logic prev_sclk = 1'b1;
    logic prev_din  = 1'b0;
    int   din_moves = 0;
    always @(negedge clk) begin
        if (rst_n && dac_sync === 1'b0 && !prev_sclk && dac_clk === 1'b0 && dac_din !== prev_din)
            din_moves <= din_moves + 1;
        prev_sclk <= dac_clk;
        prev_din  <= dac_din;
    end

    // Handshake counter, sampled just before each rising edge
    int hs_count = 0;
    always begin
        @(negedge clk);
        #4;
        if (rst_n && s_valid && s_ready === 1'b1) hs_count = hs_count + 1;
    end

    // Reference model of the word the DAC should receive
    function automatic logic [FB-1:0] frame_of(input logic [1:0] m, input logic [DW-1:0] d);
        return FB'(m) * (FB'(1) << DW) + FB'(d);
    endfunction

    // Expected pin levels in cycle k after the accepting edge
    function automatic logic exp_sync(input int k);
        return !(k >= 1 && k <= L);
    endfunction

    function automatic logic exp_sclk(input int k);
        int j;
        if (k <= int'(CD) || k > L) return 1'b1;
        j = k - int'(CD) - 1;
        return ((j / int'(CD)) % 2) == 1;
    endfunction

    function automatic logic exp_done(input int k);
        return k == L + 1;
    endfunction

    function automatic logic exp_ready(input int k);
        return k >= L + 1 + int'(SI);
    endfunction

    function automatic logic exp_busy(input int k);
        return k >= 1 && k <= L + int'(SI);
    endfunction

    // Present a sample and return at the negedge after the accepting edge t_hs
    task automatic handshake(input logic [DW-1:0] d, input logic [1:0] m, input bit hold,
                             output int t_hs, output bit ok);
        ok   = 1'b0;
        t_hs = -1;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_mode  = m;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            if (s_ready === 1'b1) begin
                t_hs = cyc + 1;
                ok   = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            if (frames.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad  = 0;
        int rise = -1;
        int c0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dac_sync, dac_clk, dac_din, s_ready, busy, frame_done} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_values: got %b required 110000",
                     {dac_sync, dac_clk, dac_din, s_ready, busy, frame_done});
        end
        rst_n = 1'b1;
        c0    = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({dac_sync, dac_clk, dac_din} !== 3'b110 || busy !== 1'b0 || frame_done !== 1'b0)
                bad++;
            if (rise < 0 && s_ready === 1'b1) rise = cyc - c0;
        end
        n_checks++;
        if (rise != int'(SI)) begin
            n_fail++;
            $display("FAIL ready_after_release: got %0d edges required %0d", rise, SI);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_lines: %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_single();
        int t, n0, mv0;
        bit ok;
        int e_sync = 0, e_sclk = 0, e_done = 0, e_ready = 0, e_busy = 0;
        int first_done = -1;
        n0  = frames.size();
        mv0 = din_moves;
        handshake(16'hA5C3, MODE_NORMAL, 1'b0, t, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_handshake: timeout got none required one");
        end
        for (int k = 1; k <= PERIOD; k++) begin
            if (k > 1) @(negedge clk);
            if (dac_sync   !== exp_sync(k))  e_sync++;
            if (dac_clk    !== exp_sclk(k))  e_sclk++;
            if (frame_done !== exp_done(k))  e_done++;
            if (s_ready    !== exp_ready(k)) e_ready++;
            if (busy       !== exp_busy(k))  e_busy++;
            if (frame_done === 1'b1 && first_done < 0) first_done = k;
        end
        n_checks++;
        if (e_sync != 0) begin n_fail++; $display("FAIL sync_wave: %0d bad cycles required 0", e_sync); end
        n_checks++;
        if (e_sclk != 0) begin n_fail++; $display("FAIL sclk_wave: %0d bad cycles required 0", e_sclk); end
        n_checks++;
        if (e_done != 0) begin n_fail++; $display("FAIL done_wave: %0d bad cycles required 0", e_done); end
        n_checks++;
        if (e_ready != 0) begin n_fail++; $display("FAIL ready_wave: %0d bad cycles required 0", e_ready); end
        n_checks++;
        if (e_busy != 0) begin n_fail++; $display("FAIL busy_wave: %0d bad cycles required 0", e_busy); end
        n_checks++;
        if (first_done != L + 1) begin
            n_fail++;
            $display("FAIL done_cycle: got T+%0d required T+%0d", first_done, L + 1);
        end
        wait_frames(n0 + 1, ok);
        n_checks++;
        if (!ok || frames[n0] !== 24'h00A5C3) begin
            n_fail++;
            $display("FAIL single_frame: got %h (ok=%0d) required 00a5c3", ok ? frames[n0] : '0, ok);
        end
        n_checks++;
        if (din_moves != mv0) begin
            n_fail++;
            $display("FAIL din_stable: %0d moves in low phase required 0", din_moves - mv0);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n0;
        bit ok1, ok2, ok;
        n0 = frames.size();
        handshake(16'h0000, MODE_NORMAL, 1'b1, t1, ok1);
        handshake(16'hFFFF, MODE_NORMAL, 1'b0, t2, ok2);
        n_checks++;
        if (!ok1 || !ok2 || (t2 - t1) != PERIOD) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", t2 - t1, PERIOD);
        end
        wait_frames(n0 + 2, ok);
        n_checks++;
        if (!ok || frames[n0] !== 24'h000000) begin
            n_fail++;
            $display("FAIL b2b_first: got %h required 000000", ok ? frames[n0] : 'x);
        end
        n_checks++;
        if (!ok || frames[n0+1] !== 24'h00FFFF) begin
            n_fail++;
            $display("FAIL b2b_second: got %h required 00ffff", ok ? frames[n0+1] : 'x);
        end
    endtask

    task automatic test_mode_random();
        int t, n0;
        bit ok;
        logic [FB-1:0] expq[$];
        logic [DW-1:0] d;
        logic [1:0]    m;
        n0 = frames.size();
        handshake(16'h1234, MODE_PD_TRI, 1'b0, t, ok);
        wait_frames(n0 + 1, ok);
        n_checks++;
        if (!ok || frames[n0] !== 24'h031234) begin
            n_fail++;
            $display("FAIL mode_tri: got %h required 031234", ok ? frames[n0] : 'x);
        end
        n0 = frames.size();
        for (int i = 0; i < 6; i++) begin
            d = DW'($urandom);
            m = 2'($urandom_range(0, 3));
            expq.push_back(frame_of(m, d));
            handshake(d, m, 1'b0, t, ok);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_frames(n0 + 6, ok);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (!ok || frames[n0+i] !== expq[i]) begin
                n_fail++;
                $display("FAIL random_frame%0d: got %h required %h", i, ok ? frames[n0+i] : 'x, expq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, n0;
        bit ok;
        bit hit = 1'b0;
        int bad = 0;
        logic [DW-1:0] d;
        logic [1:0]    m;
        n0 = frames.size();
        handshake(DW'($urandom), 2'($urandom_range(0, 3)), 1'b0, t, ok);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (dac_bits == 10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL abort_reach_bit10: got %0d bits required 10", dac_bits);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dac_sync, dac_clk, dac_din, s_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b required 1100", {dac_sync, dac_clk, dac_din, s_ready});
        end
        repeat (3) begin
            @(negedge clk);
            if (dac_clk !== 1'b1 || dac_sync !== 1'b1) bad++;
        end
        rst_n = 1'b1;
        n_checks++;
        if (bad != 0 || frames.size() != n0) begin
            n_fail++;
            $display("FAIL abort_discard: got %0d frames, %0d bad cycles required %0d, 0",
                     frames.size(), bad, n0);
        end
        d = DW'($urandom);
        m = 2'($urandom_range(0, 3));
        handshake(d, m, 1'b0, t, ok);
        wait_frames(n0 + 1, ok);
        n_checks++;
        if (!ok || frames[n0] !== frame_of(m, d)) begin
            n_fail++;
            $display("FAIL after_abort: got %h required %h", ok ? frames[n0] : 'x, frame_of(m, d));
        end
    endtask

    task automatic test_hold_data();
        int t, n0, hs0;
        bit ok;
        logic [DW-1:0] d;
        logic [1:0]    m;
        n0  = frames.size();
        hs0 = hs_count;
        d   = DW'($urandom);
        m   = 2'($urandom_range(0, 3));
        handshake(d, m, 1'b0, t, ok);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            s_mode  = 2'($urandom_range(0, 3));
        end
        s_valid = 1'b0;
        wait_frames(n0 + 1, ok);
        for (int i = 0; i < PERIOD && s_ready !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++;
        if (hs_count - hs0 != 1) begin
            n_fail++;
            $display("FAIL hold_handshakes: got %0d required 1", hs_count - hs0);
        end
        n_checks++;
        if (!ok || frames[n0] !== frame_of(m, d)) begin
            n_fail++;
            $display("FAIL hold_frame: got %h required %h", ok ? frames[n0] : 'x, frame_of(m, d));
        end
    endtask

    task automatic test_idle_sclk();
        n_checks++;
        if (stray_falls != 0) begin
            n_fail++;
            $display("FAIL stray_sclk: got %0d falls outside frames required 0", stray_falls);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mode_random();
        test_reset_mid();
        test_hold_data();
        test_idle_sclk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
